// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
// Also holds the request legality helpers used at acceptance time.
package lsu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_WRITE,
      ST_RESP
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] SIZE_WORD = 2'b10;

   // Stores only have B/H/W; loads additionally have BU/HU.
   function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
      if (store) begin
         return f3 > F3_W;
      end
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] offset);
      case (f3[1:0])
         2'b01:   return offset[0];
         2'b10:   return offset != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane selection for loads and lane merge for sub-word stores.
// Shared by the load and store paths of the load/store unit.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      byte_sel   = word[{offset, 3'b000} +: 8];
      half_sel   = offset[1] ? word[31:16] : word[15:0];
      load_data  = '0;
      store_word = word;

      case (funct3)
         F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
         F3_W:    load_data = word;
         F3_BU:   load_data = {24'h0, byte_sel};
         F3_HU:   load_data = {16'h0, half_sel};
         default: load_data = '0;
      endcase

      // Untouched lanes keep the value read back from memory.
      case (funct3[1:0])
         2'b00:   store_word[{offset, 3'b000} +: 8] = wdata[7:0];
         2'b01: begin
            if (offset[1]) store_word[31:16] = wdata[15:0];
            else           store_word[15:0]  = wdata[15:0];
         end
         default: store_word = wdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator for the RV32I core: word-indexed access, read-modify-write
// for sub-word stores, load extension, and misaligned/range/funct3 error reporting.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = 32,
   parameter int ADDR_W    = 32
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_store_i,
   input  logic [2:0]        req_funct3_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [31:0]       resp_rdata_o,
   output logic              resp_err_o,
   output logic              mem_write_o,
   output logic [1:0]        mem_size_o,
   output logic [31:0]       mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i
);

   lsu_state_e        state;
   logic              store_q;
   logic [2:0]        funct3_q;
   logic [1:0]        offset_q;
   logic [31:0]       wdata_q;
   logic [31:0]       mem_addr_q;
   logic [31:0]       mem_wdata_q;
   logic [31:0]       rdata_q;
   logic              err_q;

   logic [ADDR_W-1:0] word_idx;
   logic              req_err;
   logic [31:0]       load_data;
   logic [31:0]       store_word;

   assign word_idx = req_addr_i >> 2;
   assign req_err  = f3_illegal(req_store_i, req_funct3_i)
                   | f3_misaligned(req_funct3_i, req_addr_i[1:0])
                   | (word_idx >= ADDR_W'(MEM_WORDS));

   // Memory read data is consumed directly in WAIT, one cycle after READ drove the address.
   lsu_lane_align u_lane_align (
      .word       (mem_rdata_i),
      .offset     (offset_q),
      .funct3     (funct3_q),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .store_word (store_word)
   );

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state       <= ST_IDLE;
         store_q     <= 1'b0;
         funct3_q    <= '0;
         offset_q    <= '0;
         wdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
         case (state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  store_q  <= req_store_i;
                  funct3_q <= req_funct3_i;
                  offset_q <= req_addr_i[1:0];
                  wdata_q  <= req_wdata_i;
                  rdata_q  <= '0;
                  err_q    <= req_err;
                  if (req_err) begin
                     state <= ST_RESP;
                  end else begin
                     mem_addr_q <= 32'(word_idx);
                     if (req_store_i && (req_funct3_i == F3_W)) begin
                        mem_wdata_q <= req_wdata_i;
                        state       <= ST_WRITE;
                     end else begin
                        state <= ST_READ;
                     end
                  end
               end
            end
            ST_READ: state <= ST_WAIT;
            ST_WAIT: begin
               if (store_q) begin
                  mem_wdata_q <= store_word;
                  state       <= ST_WRITE;
               end else begin
                  rdata_q <= load_data;
                  state   <= ST_RESP;
               end
            end
            ST_WRITE: state <= ST_RESP;
            ST_RESP: begin
               if (resp_ready_i) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Decoded from the state register so reset clears the write strobe immediately.
   assign req_ready_o  = (state == ST_IDLE);
   assign resp_valid_o = (state == ST_RESP);
   assign mem_write_o  = (state == ST_WRITE);
   assign mem_size_o   = SIZE_WORD;
   assign mem_addr_o   = mem_addr_q;
   assign mem_wdata_o  = mem_wdata_q;
   assign resp_rdata_o = rdata_q;
   assign resp_err_o   = err_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts load/store requests from the RV32I core and drives the data memory's write, size, address and data pins.
- The data memory is word-indexed, has no byte lanes and returns read data one clock after the address.
- This block converts byte addresses to word indices, performs read-modify-write for SB/SH, extracts and sign/zero-extends LB/LH/LBU/LHU, and flags misaligned, out-of-range and illegal requests.
- Sits between the core's execute/memory stage and the data memory.

Parameters:
- MEM_WORDS, 32, depth of the attached data memory in 32-bit words.
- ADDR_W, 32, width of the core byte address.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- reset_ni  input  1  reset, asynchronous, active-low.
- req_valid_i  input  1  core presents a request.
- req_ready_o  output  1  block can accept a request.
- req_store_i  input  1  1 = store, 0 = load.
- req_funct3_i  input  3  RV32I funct3 (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101).
- req_addr_i  input  ADDR_W  byte address.
- req_wdata_i  input  32  store data; low bits are used for SB/SH.
- resp_valid_o  output  1  response available.
- resp_ready_i  input  1  core consumes the response.
- resp_rdata_o  output  32  extended load data; 0 for stores and errors.
- resp_err_o  output  1  misaligned, out-of-range or illegal funct3.
- mem_write_o  output  1  to data memory mem_write_i.
- mem_size_o  output  2  to data memory req_size_i; always 2'b10 (word).
- mem_addr_o  output  32  word index, i.e. byte address >> 2.
- mem_wdata_o  output  32  full word to write.
- mem_rdata_i  input  32  data memory data_o; valid in the cycle after a read address is driven.

Behaviour:
- Clock and reset: one clock, clk_i. reset_ni is asynchronous and active-low.
- Reset values: state IDLE; req_ready_o=1; resp_valid_o=0; resp_rdata_o=0; resp_err_o=0; mem_write_o=0; mem_size_o=2'b10; mem_addr_o=0; mem_wdata_o=0.
- Reset mid-operation: aborts the operation; no write is issued after reset is asserted.
- FSM states: IDLE, READ, WAIT, WRITE, RESP.
- IDLE:
  - req_ready_o=1. A request is accepted on req_valid_i & req_ready_o.
  - On acceptance, capture store flag, funct3, address and wdata.
  - Error check, evaluated on the captured request:
    - illegal funct3: store with funct3 > 010, or load funct3 of 011, 110 or 111;
    - half access with addr[0]=1;
    - word access with addr[1:0]!=0;
    - word index >= MEM_WORDS.
  - Error -> RESP with err=1. No memory write is issued.
  - Otherwise: load -> READ; SW -> WRITE; SB/SH -> READ (read-modify-write).
- READ: mem_addr_o = word index, mem_write_o=0. Next state WAIT.
- WAIT: sample mem_rdata_i into the word buffer.
  - Load: select byte lane addr[1:0] or half lane addr[1], sign- or zero-extend per funct3, -> RESP.
  - Store: merge wdata[7:0] into byte lane addr[1:0], or wdata[15:0] into half lane addr[1]; other bytes are preserved. -> WRITE.
- WRITE: mem_write_o=1 for exactly one cycle; mem_wdata_o = merged word (SW: wdata). Next state RESP.
- RESP: resp_valid_o=1; rdata and err are held stable until resp_ready_i; then -> IDLE. req_ready_o=0 in every state except IDLE.
- Latency from the acceptance edge to resp_valid_o high:
  - load: 3 cycles;
  - SW: 2 cycles;
  - SB/SH: 4 cycles;
  - error: 1 cycle.
- Back-to-back operation: the next request can be accepted in the cycle after the resp handshake. There is no overlap of requests.
- mem_write_o is 0 in every state except WRITE. mem_addr_o holds its last value in IDLE.
- Byte-address bits above the word index are ignored except for the range check.

Decomposition:
- Package lsu_pkg holds:
  - the state enum;
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - size constant SIZE_WORD=2'b10.
- One combinational sub-module, lsu_lane_align: inputs word, byte offset, funct3 and wdata; outputs the extended load value and the merged store word. It is shared by the WAIT-state load and store paths.

Test Plan:
- SW addr 0x8 data 0xDEADBEEF, then LW 0x8 -> one write at mem_addr_o=2 with 0xDEADBEEF two cycles after acceptance; the load returns 0xDEADBEEF with err=0, three cycles after acceptance.
- Memory word 2 = 0x11223344; SB addr 0x9 data 0xAA -> one read then one write of 0x1122AA44; LB 0x9 returns 0xFFFFFFAA; LBU 0x9 returns 0x000000AA.
- SH addr 0xA data 0x8001 on word 0x11223344 -> written word 0x80013344; LH 0xA returns 0xFFFF8001; LHU 0xA returns 0x00008001.
- Error requests, each giving resp_err_o=1 one cycle after acceptance with mem_write_o never asserted: LW addr 0x6, LH addr 0x3, SW addr 0x80 (index 32 >= MEM_WORDS), funct3 011 load.
- Backpressure: hold resp_ready_i=0 for 5 cycles after resp_valid_o rises -> resp_rdata_o stable and req_ready_o=0 throughout; a new request is accepted only after the handshake.
- Assert reset_ni low during WAIT of an SB -> outputs at their reset values immediately, no write issued, memory word unchanged, and a fresh LW after reset succeeds.
